// File: rtl/pipelined_mac_pkg.sv
// rtl/pipelined_mac_pkg.sv - shared width constants for the pipelined 4x4 multiplier
package pipelined_mac_pkg;

    localparam int OPW     = 4;  // operand width (a, y)
    localparam int OUTW    = 6;  // registered product width, low bits of a*y
    localparam int NSTAGES = 3;  // pipeline depth, operand sample edge to out

endpackage

// File: rtl/pipelined_mac_fa.sv
// rtl/pipelined_mac_fa.sv - combinational full-adder cell of the carry-save array
//
// Ports:
//   a, b, cin : input bits of equal weight
//   sum       : a ^ b ^ cin (same weight)
//   cout      : majority of a, b, cin (next weight up)
// Tying cin to 0 turns the cell into a half adder.
module pipelined_mac_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_mac.sv
// rtl/pipelined_mac.sv - 3-stage pipelined 4x4 unsigned carry-save multiplier
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every pipeline register and out
//   a     : 4-bit unsigned multiplicand, sampled every edge
//   y     : 4-bit unsigned multiplier, sampled every edge
//   out   : registered (a*y) mod 64, valid after the 3rd edge counting the sample edge
//
// Stage 1 (L1x) adds rows a*y0 and a*y1, stage 2 (L2x) folds in row a*y2,
// stage 3 (L3x) folds in row a*y3 and resolves the remaining carries.
// Column naming: L1k_sum has weight k, L1k_carry weight k+1; L2k_sum weight k+1,
// L2k_carry weight k+2. Each stage reads only the operand copies delayed
// alongside its data, so consecutive operand pairs never mix.
module pipelined_mac
    import pipelined_mac_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  y,
    output logic [OUTW-1:0] out
);

    // ---------------- stage 1 registers ----------------
    logic L11_sum, L12_sum, L13_sum, L14_sum;
    logic L11_carry, L12_carry, L13_carry, L14_carry;
    logic L11_a3, L12_a2, L13_a1, L14_a0;
    logic L15_y1, L16_y2, L17_y3;
    logic L1_p0;

    // ---------------- stage 2 registers ----------------
    logic L21_sum, L22_sum, L23_sum, L24_sum;
    logic L21_carry, L22_carry, L23_carry;
    logic L21_a3, L22_a2, L23_a1, L24_a0;
    logic L26_y2, L27_y3;
    logic L2_p0, L2_p1;

    // ---------------- stage 3 registers ----------------
    logic L37_y3;

    // ---------------- stage 1 datapath ----------------
    logic [OPW-1:0] pp0, pp1;
    logic [3:0]     s1_sum, s1_cout;

    assign pp0 = a & {OPW{y[0]}};
    assign pp1 = a & {OPW{y[1]}};

    // Columns 1..3 pair row0 with row1 shifted by one; column 4 holds only a3&y1.
    pipelined_mac_fa u_s1_c1 (.a(pp0[1]), .b(pp1[0]), .cin(1'b0), .sum(s1_sum[0]), .cout(s1_cout[0]));
    pipelined_mac_fa u_s1_c2 (.a(pp0[2]), .b(pp1[1]), .cin(1'b0), .sum(s1_sum[1]), .cout(s1_cout[1]));
    pipelined_mac_fa u_s1_c3 (.a(pp0[3]), .b(pp1[2]), .cin(1'b0), .sum(s1_sum[2]), .cout(s1_cout[2]));
    pipelined_mac_fa u_s1_c4 (.a(pp1[3]), .b(1'b0),   .cin(1'b0), .sum(s1_sum[3]), .cout(s1_cout[3]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            L11_sum   <= 1'b0;
            L12_sum   <= 1'b0;
            L13_sum   <= 1'b0;
            L14_sum   <= 1'b0;
            L11_carry <= 1'b0;
            L12_carry <= 1'b0;
            L13_carry <= 1'b0;
            L14_carry <= 1'b0;
            L11_a3    <= 1'b0;
            L12_a2    <= 1'b0;
            L13_a1    <= 1'b0;
            L14_a0    <= 1'b0;
            L15_y1    <= 1'b0;
            L16_y2    <= 1'b0;
            L17_y3    <= 1'b0;
            L1_p0     <= 1'b0;
        end else begin
            L11_sum   <= s1_sum[0];
            L12_sum   <= s1_sum[1];
            L13_sum   <= s1_sum[2];
            L14_sum   <= s1_sum[3];
            L11_carry <= s1_cout[0];
            L12_carry <= s1_cout[1];
            L13_carry <= s1_cout[2];
            L14_carry <= s1_cout[3];
            L11_a3    <= a[3];
            L12_a2    <= a[2];
            L13_a1    <= a[1];
            L14_a0    <= a[0];
            L15_y1    <= y[1];
            L16_y2    <= y[2];
            L17_y3    <= y[3];
            L1_p0     <= pp0[0];
        end
    end

    // ---------------- stage 2 datapath ----------------
    logic [OPW-1:0] d1_a, pp2;
    logic [3:0]     s2_sum, s2_cout;

    assign d1_a = {L11_a3, L12_a2, L13_a1, L14_a0};
    assign pp2  = d1_a & {OPW{L16_y2}};

    // Row a*y2 lands on columns 2..5.
    pipelined_mac_fa u_s2_c2 (.a(L12_sum),   .b(L11_carry), .cin(pp2[0]), .sum(s2_sum[0]), .cout(s2_cout[0]));
    pipelined_mac_fa u_s2_c3 (.a(L13_sum),   .b(L12_carry), .cin(pp2[1]), .sum(s2_sum[1]), .cout(s2_cout[1]));
    pipelined_mac_fa u_s2_c4 (.a(L14_sum),   .b(L13_carry), .cin(pp2[2]), .sum(s2_sum[2]), .cout(s2_cout[2]));
    pipelined_mac_fa u_s2_c5 (.a(L14_carry), .b(pp2[3]),    .cin(1'b0),   .sum(s2_sum[3]), .cout(s2_cout[3]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            L21_sum   <= 1'b0;
            L22_sum   <= 1'b0;
            L23_sum   <= 1'b0;
            L24_sum   <= 1'b0;
            L21_carry <= 1'b0;
            L22_carry <= 1'b0;
            L23_carry <= 1'b0;
            L21_a3    <= 1'b0;
            L22_a2    <= 1'b0;
            L23_a1    <= 1'b0;
            L24_a0    <= 1'b0;
            L26_y2    <= 1'b0;
            L27_y3    <= 1'b0;
            L2_p0     <= 1'b0;
            L2_p1     <= 1'b0;
        end else begin
            L21_sum   <= s2_sum[0];
            L22_sum   <= s2_sum[1];
            L23_sum   <= s2_sum[2];
            L24_sum   <= s2_sum[3];
            L21_carry <= s2_cout[0];
            L22_carry <= s2_cout[1];
            L23_carry <= s2_cout[2];
            L21_a3    <= L11_a3;
            L22_a2    <= L12_a2;
            L23_a1    <= L13_a1;
            L24_a0    <= L14_a0;
            L26_y2    <= L16_y2;
            L27_y3    <= L17_y3;
            L2_p0     <= L1_p0;
            L2_p1     <= L11_sum;   // column 1 is complete after stage 1
        end
    end

    // ---------------- stage 3 datapath ----------------
    logic [OPW-1:0] d2_a, pp3;
    logic [3:0]     s3_sum, s3_cout;
    logic           p5;

    assign d2_a = {L21_a3, L22_a2, L23_a1, L24_a0};
    assign pp3  = d2_a & {OPW{L27_y3}};

    // Column 3 is a plain add; column 4 needs a second cell to absorb the
    // ripple from column 3; column 5 only needs parity, so the two carries
    // arriving there are XORed in rather than given another cell.
    pipelined_mac_fa u_s3_c3  (.a(L22_sum),   .b(L21_carry),  .cin(pp3[0]), .sum(s3_sum[0]), .cout(s3_cout[0]));
    pipelined_mac_fa u_s3_c4  (.a(L23_sum),   .b(L22_carry),  .cin(pp3[1]), .sum(s3_sum[1]), .cout(s3_cout[1]));
    pipelined_mac_fa u_s3_c4r (.a(s3_sum[1]), .b(s3_cout[0]), .cin(1'b0),   .sum(s3_sum[2]), .cout(s3_cout[2]));
    pipelined_mac_fa u_s3_c5  (.a(L24_sum),   .b(L23_carry),  .cin(pp3[2]), .sum(s3_sum[3]), .cout(s3_cout[3]));

    assign p5 = s3_sum[3] ^ s3_cout[1] ^ s3_cout[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            L37_y3 <= 1'b0;
        end else begin
            out    <= {p5, s3_sum[2], s3_sum[0], L21_sum, L2_p1, L2_p0};
            L37_y3 <= L27_y3;
        end
    end

    // Weights 6 and up are dropped (product wraps mod 64); the delayed y copies
    // not consumed downstream are kept as observable pipeline state.
    logic unused_bits;
    assign unused_bits = ^{L15_y1, L26_y2, L37_y3, pp3[3], s2_cout[3], s3_cout[3]};

endmodule

// File: tb/tb_pipelined_mac.sv
// tb/tb_pipelined_mac.sv - self-checking bench for pipelined_mac
module tb_pipelined_mac;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] y;
    logic [5:0] out;

    int passed = 0;
    int total  = 0;

    // Reference: a product list delayed by three accepted edges.
    int exp_pipe [3];

    typedef struct {
        logic [3:0] a;
        logic [3:0] y;
        int         exp;
    } vec_t;

    vec_t tbl [9];

    pipelined_mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .y     (y),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) exp_pipe[i] = 0;
    endtask

    // One rising edge; the model absorbs the operands the DUT sampled, then
    // time moves 1 unit past the edge for checking / driving.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else begin
            exp_pipe[2] = exp_pipe[1];
            exp_pipe[1] = exp_pipe[0];
            exp_pipe[0] = (int'(a) * int'(y)) % 64;
        end
        #1;
    endtask

    initial begin
        tbl[0] = '{4'd9,  4'd6,  54};
        tbl[1] = '{4'd3,  4'd2,  6};
        tbl[2] = '{4'd10, 4'd5,  50};
        tbl[3] = '{4'd12, 4'd3,  36};
        tbl[4] = '{4'd5,  4'd6,  30};
        tbl[5] = '{4'd15, 4'd15, 33};
        tbl[6] = '{4'd8,  4'd8,  0};
        tbl[7] = '{4'd0,  4'd13, 0};
        tbl[8] = '{4'd11, 4'd1,  11};

        model_clear();

        // Reset held with all-ones operands, then release.
        rst_n = 1'b0;
        a = 4'd15;
        y = 4'd15;
        #1;
        chk("reset_async", int'(out), 0);
        tick();
        chk("reset_hold1", int'(out), 0);
        tick();
        chk("reset_hold2", int'(out), 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_e1", int'(out), 0);
        tick();
        chk("post_reset_e2", int'(out), 0);
        tick();
        chk("post_reset_e3", int'(out), 33);

        // Single operand with internal stage probes.
        a = 4'd9;
        y = 4'd6;
        tick();
        chk("L11_a3", int'(dut.L11_a3), 1);
        chk("L12_a2", int'(dut.L12_a2), 0);
        chk("L13_a1", int'(dut.L13_a1), 0);
        chk("L14_a0", int'(dut.L14_a0), 1);
        chk("L15_y1", int'(dut.L15_y1), 1);
        chk("L16_y2", int'(dut.L16_y2), 1);
        chk("L17_y3", int'(dut.L17_y3), 0);
        a = 4'd0;
        y = 4'd0;
        tick();
        chk("L27_y3", int'(dut.L27_y3), 0);
        tick();
        chk("single_9x6", int'(out), 54);
        chk("L37_y3", int'(dut.L37_y3), 0);

        // Back-to-back table stream: out after edge i carries vector i-2.
        for (int i = 0; i < 9; i++) begin
            a = tbl[i].a;
            y = tbl[i].y;
            tick();
            if (i >= 2) chk($sformatf("tbl_%0dx%0d", tbl[i-2].a, tbl[i-2].y), int'(out), tbl[i-2].exp);
        end
        a = 4'd0;
        y = 4'd0;
        for (int i = 7; i < 9; i++) begin
            tick();
            chk($sformatf("tbl_%0dx%0d", tbl[i].a, tbl[i].y), int'(out), tbl[i].exp);
        end

        // Mid-stream asynchronous reset.
        a = 4'd15;
        y = 4'd15;
        tick();
        tick();
        tick();
        chk("pre_mid_reset", int'(out), 33);
        a = 4'd7;
        y = 4'd7;
        tick();
        a = 4'd6;
        y = 4'd5;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_reset_out", int'(out), 0);
        chk("mid_reset_L11_a3", int'(dut.L11_a3), 0);
        #2;
        rst_n = 1'b1;
        a = 4'd2;
        y = 4'd3;
        tick();
        chk("after_mid_e1", int'(out), 0);
        a = 4'd0;
        y = 4'd0;
        tick();
        chk("after_mid_e2", int'(out), 0);
        tick();
        chk("after_mid_2x3", int'(out), 6);

        // Randomized stream against the reference, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            a = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                chk("rand_async_reset", int'(out), 0);
                rst_n = 1'b1;
            end
            tick();
            chk($sformatf("rand_%0d", n), int'(out), exp_pipe[2]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
